// File: rtl/counted_fifo.sv
// First-word-fall-through FIFO of arbitrary depth with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags.
module counted_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    parameter int CNTWID   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic [CNTWID-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRW-1:0]   PTR_LAST  = PTRW'(DEPTH - 1);
    localparam logic [CNTWID-1:0] CNT_FULL  = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] CNT_AF    = CNTWID'(AF_LEVEL);
    localparam logic [CNTWID-1:0] CNT_AE    = CNTWID'(AE_LEVEL);

    if (WIDTH < 1 || DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_param_check
        $error("counted_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTRW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTRW-1:0]   wr_ptr_next, rd_ptr_next;
    logic [CNTWID-1:0] count_reg, count_next;
    logic              overflow_reg, underflow_reg;
    logic              push_acc, pop_acc;
    logic              overflow_set, underflow_set;

    // Flags come only from the registered count, never from push/pop directly.
    assign full         = (count_reg == CNT_FULL);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CNT_AF);
    assign almost_empty = (count_reg <= CNT_AE);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    assign overflow_set  = push & full & ~pop & ~flush;
    assign underflow_set = pop & empty & ~flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_acc) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Setting an error wins over clearing it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (underflow_set) begin
                underflow_reg <= 1'b1;
            end else if (clr_err) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_acc && !flush) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    // Head is read combinationally so a written word falls through right after its edge.
    assign data_out = empty ? '0 : mem[rd_ptr_reg];

`ifdef FORMAL
    always_comb begin
        assert (count_reg <= CNT_FULL);
        assert (full == (count_reg == CNT_FULL));
        assert (empty == (count_reg == '0));
        assert (((int'(wr_ptr_reg) + DEPTH - int'(rd_ptr_reg)) % DEPTH) == (int'(count_reg) % DEPTH));
    end
`endif

endmodule

// File: tb/tb_counted_fifo.sv
// Bench for counted_fifo: directed vector table and reset case on a DEPTH=5 instance, then
// random traffic on DEPTH 2/5/8 instances against queue models.
module tb_counted_fifo;

    logic       clk = 1'b0;
    logic       rst, push, pop, flush, clr_err;
    logic [7:0] data_in;

    logic [7:0] d2_dout, d5_dout, d8_dout;
    logic [1:0] d2_cnt;
    logic [2:0] d5_cnt;
    logic [3:0] d8_cnt;
    logic       d2_full, d2_empty, d2_af, d2_ae, d2_ovf, d2_udf;
    logic       d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_udf;
    logic       d8_full, d8_empty, d8_af, d8_ae, d8_ovf, d8_udf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    counted_fifo #(.WIDTH(8), .DEPTH(2), .AF_LEVEL(2), .AE_LEVEL(0)) u_d2 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .data_out(d2_dout), .count(d2_cnt), .full(d2_full), .empty(d2_empty),
        .almost_full(d2_af), .almost_empty(d2_ae), .overflow(d2_ovf), .underflow(d2_udf));

    counted_fifo #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .data_out(d5_dout), .count(d5_cnt), .full(d5_full), .empty(d5_empty),
        .almost_full(d5_af), .almost_empty(d5_ae), .overflow(d5_ovf), .underflow(d5_udf));

    counted_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) u_d8 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .data_out(d8_dout), .count(d8_cnt), .full(d8_full), .empty(d8_empty),
        .almost_full(d8_af), .almost_empty(d8_ae), .overflow(d8_ovf), .underflow(d8_udf));

    // Per-instance views: index 0 = DEPTH 2, 1 = DEPTH 5, 2 = DEPTH 8. Flags {full,empty,af,ae,ovf,udf}.
    int         act_cnt [3];
    logic [7:0] act_dout [3];
    logic [5:0] act_flg [3];
    always_comb begin
        act_cnt[0]  = int'(d2_cnt);
        act_cnt[1]  = int'(d5_cnt);
        act_cnt[2]  = int'(d8_cnt);
        act_dout[0] = d2_dout;
        act_dout[1] = d5_dout;
        act_dout[2] = d8_dout;
        act_flg[0]  = {d2_full, d2_empty, d2_af, d2_ae, d2_ovf, d2_udf};
        act_flg[1]  = {d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_udf};
        act_flg[2]  = {d8_full, d8_empty, d8_af, d8_ae, d8_ovf, d8_udf};
    end

    task automatic chk(string name, int act, int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit ps, bit pp, bit fl, bit ce, logic [7:0] din);
        push = ps; pop = pp; flush = fl; clr_err = ce; data_in = din;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 8'h00);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         ps, pp, fl, ce;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic [5:0] flg;
    } vec_t;
    vec_t vecs[$];

    task automatic add(bit ps, bit pp, bit fl, bit ce, logic [7:0] din,
                       int cnt, logic [7:0] dout, logic [5:0] flg);
        vec_t v;
        v.ps = ps; v.pp = pp; v.fl = fl; v.ce = ce; v.din = din;
        v.cnt = cnt; v.dout = dout; v.flg = flg;
        vecs.push_back(v);
    endtask

    // Queue reference models
    int         dep  [3] = '{2, 5, 8};
    int         afl  [3] = '{2, 4, 6};
    int         ael  [3] = '{0, 1, 1};
    logic [7:0] mq   [3][$];
    bit         m_ovf [3];
    bit         m_udf [3];

    task automatic model_step(int k, bit ps, bit pp, bit fl, bit ce, logic [7:0] din);
        int n;
        bit pok, wok;
        n = mq[k].size();
        if (fl) begin
            mq[k] = {};
            if (ce) begin
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
            end
        end else begin
            pok = pp && (n > 0);
            wok = ps && ((n < dep[k]) || pok);
            if (ps && n == dep[k] && !pp) m_ovf[k] = 1'b1;
            else if (ce)                  m_ovf[k] = 1'b0;
            if (pp && n == 0)             m_udf[k] = 1'b1;
            else if (ce)                  m_udf[k] = 1'b0;
            if (pok) void'(mq[k].pop_front());
            if (wok) mq[k].push_back(din);
        end
    endtask

    task automatic model_check(int k);
        int n;
        logic [5:0] ef;
        logic [7:0] ed;
        n  = mq[k].size();
        ed = (n > 0) ? mq[k][0] : 8'h00;
        ef = {n == dep[k], n == 0, n >= afl[k], n <= ael[k], m_ovf[k], m_udf[k]};
        chk($sformatf("rnd d%0d count", dep[k]), act_cnt[k], n);
        chk($sformatf("rnd d%0d data_out", dep[k]), int'(act_dout[k]), int'(ed));
        chk($sformatf("rnd d%0d flags", dep[k]), int'(act_flg[k]), int'(ef));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ps, pp, fl, ce;
        logic [7:0] din;
        int pct;

        // flags column: {full, empty, almost_full, almost_empty, overflow, underflow}
        // Wrap-around with data ordering
        add(1,0,0,0,8'h10, 1,8'h10,6'b000100);
        add(1,0,0,0,8'h11, 2,8'h10,6'b000000);
        add(1,0,0,0,8'h12, 3,8'h10,6'b000000);
        add(1,0,0,0,8'h13, 4,8'h10,6'b001000);
        add(1,0,0,0,8'h14, 5,8'h10,6'b101000);
        add(0,1,0,0,8'h00, 4,8'h11,6'b001000);
        add(0,1,0,0,8'h00, 3,8'h12,6'b000000);
        add(0,1,0,0,8'h00, 2,8'h13,6'b000000);
        add(1,0,0,0,8'h20, 3,8'h13,6'b000000);
        add(1,0,0,0,8'h21, 4,8'h13,6'b001000);
        add(1,0,0,0,8'h22, 5,8'h13,6'b101000);
        add(0,1,0,0,8'h00, 4,8'h14,6'b001000);
        add(0,1,0,0,8'h00, 3,8'h20,6'b000000);
        add(0,1,0,0,8'h00, 2,8'h21,6'b000000);
        add(0,1,0,0,8'h00, 1,8'h22,6'b000100);
        add(0,1,0,0,8'h00, 0,8'h00,6'b010100);
        // Full: simultaneous push/pop accepted, lone push overflows
        add(1,0,0,0,8'h30, 1,8'h30,6'b000100);
        add(1,0,0,0,8'h31, 2,8'h30,6'b000000);
        add(1,0,0,0,8'h32, 3,8'h30,6'b000000);
        add(1,0,0,0,8'h33, 4,8'h30,6'b001000);
        add(1,0,0,0,8'h34, 5,8'h30,6'b101000);
        add(1,1,0,0,8'hAA, 5,8'h31,6'b101000);
        add(1,0,0,0,8'hBB, 5,8'h31,6'b101010);
        add(0,1,0,0,8'h00, 4,8'h32,6'b001010);
        add(0,1,0,0,8'h00, 3,8'h33,6'b000010);
        add(0,1,0,0,8'h00, 2,8'h34,6'b000010);
        add(0,1,0,0,8'h00, 1,8'hAA,6'b000110);
        add(0,1,0,0,8'h00, 0,8'h00,6'b010110);
        // Empty: lone pop underflows, push+pop on empty accepts only the push
        add(0,1,0,0,8'h00, 0,8'h00,6'b010111);
        add(1,1,0,0,8'h33, 1,8'h33,6'b000111);
        add(0,0,0,1,8'h00, 1,8'h33,6'b000100);
        add(0,1,0,0,8'h00, 0,8'h00,6'b010100);
        // Flush with push and pop asserted, then refill
        add(1,0,0,0,8'h50, 1,8'h50,6'b000100);
        add(1,0,0,0,8'h51, 2,8'h50,6'b000000);
        add(1,0,0,0,8'h52, 3,8'h50,6'b000000);
        add(1,1,1,0,8'h99, 0,8'h00,6'b010100);
        add(1,0,0,0,8'h44, 1,8'h44,6'b000100);
        add(0,1,0,0,8'h00, 0,8'h00,6'b010100);
        // Underflow set wins over clr_err in the same cycle
        add(0,1,0,1,8'h00, 0,8'h00,6'b010101);
        add(0,0,0,1,8'h00, 0,8'h00,6'b010100);

        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00);
        #1 rst = 1'b1;
        #1;
        chk("reset count", act_cnt[1], 0);
        chk("reset flags", int'(act_flg[1]), int'(6'b010100));
        chk("reset data_out", int'(act_dout[1]), 0);
        step();
        rst = 1'b0;

        // Asynchronous reset in the middle of traffic
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 8'(i));
            step();
        end
        drive(0, 0, 0, 0, 8'h00);
        chk("pre-rst count", act_cnt[1], 3);
        chk("pre-rst data_out", int'(act_dout[1]), 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst count", act_cnt[1], 0);
        chk("async rst empty", int'(d5_empty), 1);
        chk("async rst data_out", int'(act_dout[1]), 0);
        step();
        rst = 1'b0;
        $display("[TB] reset mid-traffic done");

        foreach (vecs[i]) begin
            drive(vecs[i].ps, vecs[i].pp, vecs[i].fl, vecs[i].ce, vecs[i].din);
            step();
            $display("[TB] vec %0d push=%0b pop=%0b flush=%0b clr=%0b din=%02h -> count=%0d dout=%02h flags=%06b",
                     i, vecs[i].ps, vecs[i].pp, vecs[i].fl, vecs[i].ce, vecs[i].din,
                     act_cnt[1], act_dout[1], act_flg[1]);
            chk($sformatf("vec%0d count", i), act_cnt[1], vecs[i].cnt);
            chk($sformatf("vec%0d data_out", i), int'(act_dout[1]), int'(vecs[i].dout));
            chk($sformatf("vec%0d flags", i), int'(act_flg[1]), int'(vecs[i].flg));
        end

        // Random traffic against queue models on all three depths
        do_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k] = {};
            m_ovf[k] = 1'b0;
            m_udf[k] = 1'b0;
            model_check(k);
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pct = ((cyc / 400) % 2 == 0) ? 70 : 30;
            ps  = ($urandom_range(99) < pct);
            pp  = ($urandom_range(99) < 100 - pct);
            fl  = ($urandom_range(63) == 0);
            ce  = ($urandom_range(31) == 0);
            din = 8'($urandom);
            drive(ps, pp, fl, ce, din);
            for (int k = 0; k < 3; k++) model_step(k, ps, pp, fl, ce, din);
            step();
            for (int k = 0; k < 3; k++) model_check(k);
        end
        drive(0, 0, 0, 0, 8'h00);
        $display("[TB] random traffic done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
